// File: rtl/mini_fsm_pkg.sv
// Shared widths and FSM state encoding for the mini_fsm byte-packing block.
package mini_fsm_pkg;

  localparam int IN_W      = 8;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_W     = 16;
  localparam int OUT_DEPTH = 2;
  localparam int IN_AW     = 2;
  localparam int OUT_AW    = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mini_ram.sv
// Small register-file RAM: one synchronous write port, one asynchronous read
// port, and a synchronous active-low clear of every entry.
module mini_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/mini_fsm_top.sv
// Batch packer: reads byte pairs from a 4x8 input RAM and writes them as
// {odd, even} 16-bit words into a 2x16 output RAM, then raises done.
module mini_fsm_top
  import mini_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ram_in_we,
  input  logic [IN_AW-1:0] ram_in_addr_wr,
  input  logic [IN_W-1:0]  ram_in_data_wr,
  output logic             ram_out_we,
  output logic [OUT_AW-1:0] ram_out_addr_wr,
  output logic [OUT_W-1:0] ram_out_data_wr,
  output logic             done
);

  state_t              state, state_nxt;
  logic [OUT_AW-1:0]   k;
  logic [IN_W-1:0]     lo;
  logic [IN_W-1:0]     rd_data;
  logic [IN_AW-1:0]    rd_addr;
  logic [OUT_W-1:0]    out_rd_unused;

  // Even address while collecting the low byte, odd address for the high byte.
  assign rd_addr = {k, (state == RD_HI)};

  mini_ram #(
    .DATA_W (IN_W),
    .DEPTH  (IN_DEPTH),
    .AW     (IN_AW)
  ) u_ram_in (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_in_we),
    .waddr (ram_in_addr_wr),
    .wdata (ram_in_data_wr),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  mini_ram #(
    .DATA_W (OUT_W),
    .DEPTH  (OUT_DEPTH),
    .AW     (OUT_AW)
  ) u_ram_out (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_out_we),
    .waddr (ram_out_addr_wr),
    .wdata (ram_out_data_wr),
    .raddr ('0),
    .rdata (out_rd_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_LO;
      RD_LO:   state_nxt = RD_HI;
      RD_HI:   state_nxt = WR;
      WR:      state_nxt = (k == OUT_AW'(OUT_DEPTH - 1)) ? DONE : RD_LO;
      DONE:    if (start) state_nxt = RD_LO;
      default: state_nxt = IDLE;
    endcase
  end

  // Low byte latch is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state == RD_LO) lo <= rd_data;
  end

  // Output strobe/address/data are registered so they line up with WR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k               <= '0;
      done            <= 1'b0;
      ram_out_we      <= 1'b0;
      ram_out_addr_wr <= '0;
      ram_out_data_wr <= '0;
    end else begin
      ram_out_we <= (state == RD_HI);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            k    <= '0;
            done <= 1'b0;
          end
        end
        RD_HI: begin
          ram_out_addr_wr <= k;
          ram_out_data_wr <= {rd_data, lo};
        end
        WR: begin
          if (k == OUT_AW'(OUT_DEPTH - 1)) done <= 1'b1;
          else                             k    <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_fsm_top.sv
// Scoreboard bench for mini_fsm_top: expected output-RAM writes are queued at
// start and matched (address, data, cycle) as each write strobe appears.
module tb_mini_fsm_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ram_in_we = 1'b0;
  logic [1:0]  ram_in_addr_wr = '0;
  logic [7:0]  ram_in_data_wr = '0;
  logic        ram_out_we;
  logic        ram_out_addr_wr;
  logic [15:0] ram_out_data_wr;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mini_fsm_top dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ram_in_we       (ram_in_we),
    .ram_in_addr_wr  (ram_in_addr_wr),
    .ram_in_data_wr  (ram_in_data_wr),
    .ram_out_we      (ram_out_we),
    .ram_out_addr_wr (ram_out_addr_wr),
    .ram_out_data_wr (ram_out_data_wr),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ram_out_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_we", 32'(ram_out_addr_wr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("we_addr", 32'(ram_out_addr_wr), 32'(e.addr));
        chk("we_data", 32'(ram_out_data_wr), 32'(e.data));
        chk("we_cyc",  32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wr_in(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ram_in_we = 1'b1; ram_in_addr_wr = a; ram_in_data_wr = d;
    @(posedge clk); #1;
    ram_in_we = 1'b0;
  endtask

  // Cycle n of a run is the interval after edge T(n-1); T0 samples start.
  task automatic run(input logic [15:0] e0, input logic [15:0] e1,
                     input int wr_cyc, input logic [1:0] wr_a, input logic [7:0] wr_d,
                     input int st_cyc, input int rst_cyc);
    int c0;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    if (rst_cyc == 0 || rst_cyc > 3) begin
      e.addr = 1'b0; e.data = e0; e.cyc = c0 + 2; sb.push_back(e);
    end
    if (rst_cyc == 0 || rst_cyc > 6) begin
      e.addr = 1'b1; e.data = e1; e.cyc = c0 + 5; sb.push_back(e);
    end
    for (int n = 1; n <= 9; n++) begin
      ram_in_we      = (n == wr_cyc);
      ram_in_addr_wr = wr_a;
      ram_in_data_wr = wr_d;
      start          = (n == st_cyc);
      rst_n          = !(n == rst_cyc);
      @(negedge clk);
      if (rst_cyc == 0) begin
        if (n == 1) chk("done_low_c1", 32'(done), 0);
        if (n == 6) chk("done_low_c6", 32'(done), 0);
        if (n == 7) chk("done_c7", 32'(done), 1);
        if (n == 9) begin
          chk("done_held", 32'(done), 1);
          chk("hold_addr", 32'(ram_out_addr_wr), 1);
          chk("hold_data", 32'(ram_out_data_wr), 32'(e1));
          chk("oram0", 32'(dut.u_ram_out.mem[0]), 32'(e0));
          chk("oram1", 32'(dut.u_ram_out.mem[1]), 32'(e1));
        end
      end else if (n == 9) begin
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(ram_out_we), 0);
        chk("rst_data", 32'(ram_out_data_wr), 0);
        chk("rst_oram0", 32'(dut.u_ram_out.mem[0]), 0);
      end
      @(posedge clk); #1;
    end
    ram_in_we = 1'b0;
    start     = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_we",   32'(ram_out_we), 0);
    chk("rst_out_addr", 32'(ram_out_addr_wr), 0);
    chk("rst_out_data", 32'(ram_out_data_wr), 0);
    chk("rst_out_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_done", 32'(done), 0);

    wr_in(2'd0, 8'h24);
    wr_in(2'd1, 8'h81);
    wr_in(2'd2, 8'h09);
    wr_in(2'd3, 8'h63);
    run(16'h8124, 16'h6309, 0, 2'd0, 8'h00, 0, 0);

    wr_in(2'd1, 8'hFF);
    run(16'hFF24, 16'h6309, 0, 2'd0, 8'h00, 0, 0);

    run(16'hFF24, 16'h6309, 0, 2'd0, 8'h00, 2, 0);

    run(16'hFF24, 16'hAA09, 3, 2'd3, 8'hAA, 0, 0);

    run(16'hFF24, 16'hAA09, 4, 2'd2, 8'h55, 0, 0);
    run(16'hFF24, 16'hAA55, 0, 2'd0, 8'h00, 0, 0);

    run(16'hFF24, 16'h0000, 0, 2'd0, 8'h00, 0, 4);
    run(16'h0000, 16'h0000, 0, 2'd0, 8'h00, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
